mem_io_responder: RTL and testbench

Responder side of the CPU byte-wide memory bus: accepts `mem_a`/`mem_wr`/`mem_dout` from the CPU and returns read data on `mem_din` one cycle later. It contains the 128 KB RAM and the memory-mapped I/O block at `0x30000`: a UART RX byte queue, a UART TX byte queue, a free-running clock counter and a program-stop flag. It also generates `io_buffer_full` back to the CPU. It sits between the CPU top and the board UART in simulation and FPGA builds.

---
 rtl/mem_io_pkg.sv | 14 +
 rtl/byte_fifo.sv | 47 ++++
 rtl/mem_io_responder.sv | 129 ++++++++++++
 tb/tb_mem_io_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU-side memory responder: I/O decode addresses
// and FIFO defaults.
package mem_io_pkg;
  localparam logic [17:0] IO_UART_ADDR   = 18'h30000;
  localparam logic [17:0] IO_CNT_ADDR    = 18'h30004;
  localparam int          IO_SEL_HI      = 17;
  localparam int          IO_SEL_LO      = 16;
  localparam logic [1:0]  IO_SEL_VAL     = 2'b11;
  localparam int          FIFO_DEPTH_DEF = 16;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Head is forced to zero when empty so the output has a defined reset value.
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM plus memory-mapped UART FIFOs, cycle counter
// and program-stop flag, with one-cycle registered read data.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]  ram [2**RAM_AW];
  logic [7:0]  ram_rd_q;
  logic        src_ram_q;
  logic [7:0]  io_rd_q, io_rd_d;
  logic [31:0] cycle_cnt_q, cnt_snap_q, cnt_snap_d;
  logic        stop_req_q, stop_req_d, stop_pending_q, stop_pending_d;
  logic        tx_overflow_q, tx_overflow_d, done_q;

  logic [17:0] addr;
  logic        io_hit, uart_hit, cnt_hit, rd_acc, wr_acc, ram_we;
  logic        rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head, tx_din;
  logic        tx_full, tx_empty, tx_pop, tx_push, tx_can_push;
  logic        cpu_tx_req, cpu_tx_push, stop_wr, zero_req, zero_push;
  logic [CW-1:0] tx_count, rx_count_unused, tx_free;
  logic        unused_hi;

  assign addr      = mem_a[17:0];
  assign unused_hi = ^mem_a[31:18];
  assign io_hit    = (addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
  assign uart_hit  = (addr == IO_UART_ADDR);
  assign cnt_hit   = (addr[17:2] == IO_CNT_ADDR[17:2]);
  assign rd_acc    = rdy_in & ~mem_wr;
  assign wr_acc    = rdy_in & mem_wr;
  assign ram_we    = wr_acc & ~io_hit;

  assign rx_ready  = ~rx_full;
  assign rx_pop    = rd_acc & io_hit & uart_hit;
  assign tx_valid  = ~tx_empty;
  assign tx_pop    = tx_valid & tx_ready;

  // CPU bytes take priority over the deferred stop marker on a shared cycle.
  assign tx_can_push = ~tx_full | tx_pop;
  assign cpu_tx_req  = wr_acc & io_hit & uart_hit & (mem_dout != 8'h00);
  assign cpu_tx_push = cpu_tx_req & tx_can_push;
  assign stop_wr     = wr_acc & io_hit & (addr == IO_CNT_ADDR);
  assign zero_req    = stop_wr | stop_pending_q;
  assign zero_push   = zero_req & tx_can_push & ~cpu_tx_req;
  assign tx_push     = cpu_tx_push | zero_push;
  assign tx_din      = cpu_tx_push ? mem_dout : 8'h00;

  assign tx_free        = CW'(FIFO_DEPTH) - tx_count;
  assign io_buffer_full = (tx_free <= CW'(FULL_MARGIN));
  assign program_done   = done_q | (stop_req_q & ~stop_pending_q & tx_empty);
  assign mem_din        = src_ram_q ? ram_rd_q : io_rd_q;

  always_comb begin
    io_rd_d        = 8'h00;
    cnt_snap_d     = cnt_snap_q;
    stop_req_d     = stop_req_q | stop_wr;
    stop_pending_d = zero_req & ~zero_push;
    tx_overflow_d  = tx_overflow_q | (cpu_tx_req & ~tx_can_push);
    if (uart_hit) begin
      io_rd_d = rx_head;
    end else if (cnt_hit) begin
      // Byte 0 comes from the live counter; bytes 1-3 from the snapshot it takes.
      io_rd_d = (addr[1:0] == 2'd0) ? cycle_cnt_q[7:0] : byte_of(cnt_snap_q, addr[1:0]);
    end
    if (rd_acc && io_hit && addr == IO_CNT_ADDR) cnt_snap_d = cycle_cnt_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt_q    <= '0;
      cnt_snap_q     <= '0;
      stop_req_q     <= 1'b0;
      stop_pending_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
      done_q         <= 1'b0;
      src_ram_q      <= 1'b0;
      io_rd_q        <= 8'h00;
    end else begin
      cycle_cnt_q    <= cycle_cnt_q + 32'd1;
      cnt_snap_q     <= cnt_snap_d;
      stop_req_q     <= stop_req_d;
      stop_pending_q <= stop_pending_d;
      tx_overflow_q  <= tx_overflow_d;
      done_q         <= program_done;
      if (rdy_in) begin
        src_ram_q <= ~mem_wr & ~io_hit;
        io_rd_q   <= (~mem_wr & io_hit) ? io_rd_d : 8'h00;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    if (rdy_in) ram_rd_q <= ram[mem_a[RAM_AW-1:0]];
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_in), .rst_ni(rst_in),
    .push_i(rx_valid & rx_ready), .data_i(rx_data), .pop_i(rx_pop),
    .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count_unused)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_in), .rst_ni(rst_in),
    .push_i(tx_push), .data_i(tx_din), .pop_i(tx_pop),
    .data_o(tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        program_done;

  int n_cmp = 0;
  int n_err = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .program_done(program_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    rdy_in = 1'b1; mem_a = a; mem_wr = wr; mem_dout = d;
    tick();
    rdy_in = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_mem_din", 32'(mem_din), 32'h00);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("rst_ibf", 32'(io_buffer_full), 32'h0);
    chk("rst_done", 32'(program_done), 32'h0);

    // Counter: 100 edges after reset release, then a coherent 4-byte read.
    for (int i = 0; i < 100; i++) tick();
    bus(32'h30004, 1'b0, 8'h00); chk("cnt_b0", 32'(mem_din), 32'h64);
    bus(32'h30005, 1'b0, 8'h00); chk("cnt_b1", 32'(mem_din), 32'h00);
    bus(32'h30006, 1'b0, 8'h00); chk("cnt_b2", 32'(mem_din), 32'h00);
    bus(32'h30007, 1'b0, 8'h00); chk("cnt_b3", 32'(mem_din), 32'h00);
    force dut.cycle_cnt_q = 32'h0001FFFF;
    #1 release dut.cycle_cnt_q;
    bus(32'h30004, 1'b0, 8'h00); chk("snap_b0", 32'(mem_din), 32'hFF);
    bus(32'h30005, 1'b0, 8'h00); chk("snap_b1", 32'(mem_din), 32'hFF);
    bus(32'h30006, 1'b0, 8'h00); chk("snap_b2", 32'(mem_din), 32'h01);
    bus(32'h30007, 1'b0, 8'h00); chk("snap_b3", 32'(mem_din), 32'h00);
    force dut.cycle_cnt_q = 32'hFFFFFFFE;
    #1 release dut.cycle_cnt_q;
    tick(); chk("cnt_max", dut.cycle_cnt_q, 32'hFFFFFFFF);
    tick(); chk("cnt_wrap", dut.cycle_cnt_q, 32'h00000000);

    // RAM write-then-read, read hold with rdy low, and ignored write with rdy low.
    bus(32'h00010, 1'b1, 8'hA5);
    bus(32'h00010, 1'b0, 8'h00); chk("ram_rd", 32'(mem_din), 32'hA5);
    mem_a = 32'h00011; tick(); chk("din_hold", 32'(mem_din), 32'hA5);
    bus(32'h00011, 1'b1, 8'h3C);
    mem_a = 32'h00011; mem_wr = 1'b1; mem_dout = 8'h77; tick(); mem_wr = 1'b0;
    bus(32'h00011, 1'b0, 8'h00); chk("ram_nordy", 32'(mem_din), 32'h3C);
    bus(32'h30010, 1'b0, 8'h00); chk("io_other", 32'(mem_din), 32'h00);

    // RX queue ordering, empty read, and full.
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick(); rx_valid = 1'b0;
    bus(32'h30000, 1'b0, 8'h00); chk("rx_pop1", 32'(mem_din), 32'h41);
    bus(32'h30000, 1'b0, 8'h00); chk("rx_pop2", 32'(mem_din), 32'h42);
    bus(32'h30000, 1'b0, 8'h00); chk("rx_empty", 32'(mem_din), 32'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(i + 1); tick();
      if (i == 14) chk("rx_ready15", 32'(rx_ready), 32'h1);
    end
    rx_valid = 1'b0;
    chk("rx_full", 32'(rx_ready), 32'h0);

    // TX: zero filter, near-full flag, overflow.
    tx_ready = 1'b0;
    bus(32'h30000, 1'b1, 8'h00); chk("tx_zero", 32'(tx_valid), 32'h0);
    for (int i = 0; i < 13; i++) bus(32'h30000, 1'b1, 8'h48);
    chk("ibf_13", 32'(io_buffer_full), 32'h0);
    bus(32'h30000, 1'b1, 8'h48);
    chk("ibf_14", 32'(io_buffer_full), 32'h1);
    chk("tx_head", 32'(tx_data), 32'h48);
    bus(32'h30000, 1'b1, 8'h48); bus(32'h30000, 1'b1, 8'h48);
    chk("ovf_16", 32'(dut.tx_overflow_q), 32'h0);
    bus(32'h30000, 1'b1, 8'h48);
    chk("ovf_17", 32'(dut.tx_overflow_q), 32'h1);

    // Reset mid-transfer with both FIFOs non-empty and mem_din non-zero.
    bus(32'h00010, 1'b0, 8'h00); chk("pre_rst_din", 32'(mem_din), 32'hA5);
    rst_in = 1'b0; #1;
    chk("arst_mem_din", 32'(mem_din), 32'h00);
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_tx_data", 32'(tx_data), 32'h00);
    chk("arst_rx_ready", 32'(rx_ready), 32'h1);
    chk("arst_ibf", 32'(io_buffer_full), 32'h0);
    chk("arst_done", 32'(program_done), 32'h0);
    tick(); rst_in = 1'b1; tick();
    bus(32'h30000, 1'b0, 8'h00); chk("post_rst_rx", 32'(mem_din), 32'h00);
    chk("post_rst_tx", 32'(tx_valid), 32'h0);
    chk("post_rst_ovf", 32'(dut.tx_overflow_q), 32'h0);

    // Stop with three bytes queued: marker drains last, then done.
    bus(32'h30000, 1'b1, 8'h31); bus(32'h30000, 1'b1, 8'h32); bus(32'h30000, 1'b1, 8'h33);
    bus(32'h30004, 1'b1, 8'h01);
    chk("stop_done0", 32'(program_done), 32'h0);
    tx_ready = 1'b1;
    chk("stop_tx0", 32'(tx_data), 32'h31); chk("stop_dn0", 32'(program_done), 32'h0); tick();
    chk("stop_tx1", 32'(tx_data), 32'h32); chk("stop_dn1", 32'(program_done), 32'h0); tick();
    chk("stop_tx2", 32'(tx_data), 32'h33); chk("stop_dn2", 32'(program_done), 32'h0); tick();
    chk("stop_tx3", 32'(tx_data), 32'h00); chk("stop_vld3", 32'(tx_valid), 32'h1);
    chk("stop_dn3", 32'(program_done), 32'h0); tick();
    chk("stop_empty", 32'(tx_valid), 32'h0);
    chk("stop_done", 32'(program_done), 32'h1);
    tx_ready = 1'b0;
    tick(); chk("stop_sticky", 32'(program_done), 32'h1);

    // Stop with TX full: marker deferred until a slot frees.
    do_reset();
    for (int i = 0; i < 16; i++) bus(32'h30000, 1'b1, 8'(8'h50 + i));
    bus(32'h30004, 1'b1, 8'h01);
    chk("full_pend", 32'(dut.stop_pending_q), 32'h1);
    chk("full_done0", 32'(program_done), 32'h0);
    tx_ready = 1'b1;
    chk("full_tx0", 32'(tx_data), 32'h50);
    tick(); tx_ready = 1'b0;
    chk("full_pend_clr", 32'(dut.stop_pending_q), 32'h0);
    chk("full_ibf", 32'(io_buffer_full), 32'h1);
    tx_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("full_txn", 32'(tx_data), 32'(8'h50 + i));
      tick();
    end
    chk("full_marker", 32'(tx_data), 32'h00);
    chk("full_done1", 32'(program_done), 32'h0);
    tick();
    chk("full_empty", 32'(tx_valid), 32'h0);
    chk("full_done", 32'(program_done), 32'h1);
    tx_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
